// File: rtl/seq_normalizer_8bit_if.sv
// rtl/seq_normalizer_8bit_if.sv - operand/result handshake bundle for seq_normalizer_8bit.
interface seq_normalizer_8bit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] shamt_out;
  logic             zero_flag;

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  shamt_out,
    input  zero_flag
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out,
    output shamt_out,
    output zero_flag
  );
endinterface

// File: rtl/seq_normalizer_8bit.sv
// rtl/seq_normalizer_8bit.sv - multi-cycle left normalizer returning data with MSB set plus shift count.
// Optional FAST_SHIFT2_EN: shift two bits per cycle while the top two work bits are both zero.
module seq_normalizer_8bit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_normalizer_8bit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.data_in;
          cnt_d  = '0;
          zero_d = (bus.data_in == '0);
          // Zero and already-normalized operands skip SHIFT entirely.
          if ((bus.data_in == '0) || bus.data_in[WIDTH-1]) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
`ifdef FAST_SHIFT2_EN
        // Two leading zeros on a nonzero word guarantee at least two shifts remain.
        if (work_q[WIDTH-1:WIDTH-2] == 2'b00) begin
          work_d = work_q << 2;
          cnt_d  = cnt_q + CNT_W'(2);
        end else begin
          work_d = work_q << 1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
`else
        work_d = work_q << 1;
        cnt_d  = cnt_q + CNT_W'(1);
`endif
        if (work_d[WIDTH-1]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.data_out  = work_q;
  assign bus.shamt_out = cnt_q;
  assign bus.zero_flag = zero_q;

  a_done_normalized : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DONE && !zero_q) |-> work_q[WIDTH-1]);

  a_hold_when_stalled : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DONE && !bus.out_ready) |=>
      (state_q == DONE && $stable(work_q) && $stable(cnt_q) && $stable(zero_q)));

endmodule

// File: tb/tb_seq_normalizer_8bit.sv
// tb/tb_seq_normalizer_8bit.sv - randomized self-checking bench for seq_normalizer_8bit.
module tb_seq_normalizer_8bit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_normalizer_8bit_if #(.WIDTH(8), .CNT_W(3)) bus ();

  seq_normalizer_8bit #(.WIDTH(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: locate the highest set bit, shift it to the top.
  task automatic ref_norm(input logic [7:0] x, output logic [7:0] d, output int sh,
                          output bit z, output int lat);
    int top;
    top = -1;
    for (int i = 0; i < 8; i++) if (x[i]) top = i;
    z = (top < 0);
    sh = z ? 0 : 7 - top;
    d = x << sh;
`ifdef FAST_SHIFT2_EN
    lat = (sh + 1) / 2;
`else
    lat = sh;
`endif
  endtask

  task automatic run_op(input logic [7:0] x, input int stall, input bit early);
    logic [7:0] exp_d;
    int         exp_sh;
    bit         exp_z;
    int         exp_lat;
    int         n;
    ref_norm(x, exp_d, exp_sh, exp_z, exp_lat);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.data_in   = x;
    bus.out_ready = early;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.data_in  = 8'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("data_out", 32'(bus.data_out), 32'(exp_d));
    check("shamt_out", 32'(bus.shamt_out), 32'(exp_sh));
    check("zero_flag", 32'(bus.zero_flag), 32'(exp_z));
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      bus.data_in  = 8'($urandom);
      @(posedge clk); #1;
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_data", 32'(bus.data_out), 32'(exp_d));
      check("stall_shamt", 32'(bus.shamt_out), 32'(exp_sh));
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_shamt", 32'(bus.shamt_out), 32'd0);
    check("rst_zero", 32'(bus.zero_flag), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h01, 0, 1'b1);
    run_op(8'hB3, 0, 1'b1);
    run_op(8'h13, 0, 1'b1);
    run_op(8'h40, 0, 1'b1);
    run_op(8'h00, 0, 1'b1);
    run_op(8'h05, 6, 1'b0);
    run_op(8'h80, 2, 1'b0);
    run_op(8'h02, 0, 1'b0);

    // Asynchronous reset in the middle of SHIFT.
    bus.in_valid = 1'b1;
    bus.data_in  = 8'h02;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data", 32'(bus.data_out), 32'd0);
    check("arst_shamt", 32'(bus.shamt_out), 32'd0);
    check("arst_zero", 32'(bus.zero_flag), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_idle", 32'(bus.out_valid), 32'd0);
    run_op(8'h20, 0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] x;
      bit         early;
      x     = 8'($urandom);
      x     = x >> $urandom_range(0, 7);
      early = 1'($urandom);
      run_op(x, early ? 0 : $urandom_range(0, 3), early);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
